// File: rtl/snake_pkg.sv
// Shared definitions for the snake game control path: direction encodings,
// the reversal helper and the default key debounce interval.
package snake_pkg;

    typedef logic [3:0] dir_t;

    localparam dir_t DIR_UP    = 4'b1000;
    localparam dir_t DIR_DOWN  = 4'b0100;
    localparam dir_t DIR_LEFT  = 4'b0010;
    localparam dir_t DIR_RIGHT = 4'b0001;

    // 10 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500_000;

    function automatic dir_t opposite_dir(input dir_t d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push button: 2-flop synchronizer, stability counter, debounced level
// and a one-cycle pulse on each accepted press.
module key_debounce
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int             CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  TC = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= ~key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == TC) begin
                // level about to rise means this is a press, not a release
                level <= ~level;
                press <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/dir_control.sv
// Turns debounced direction key presses into a one-hot snake direction that
// only changes on game ticks and never reverses onto itself.
module dir_control
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_n,
    input  logic       tick,
    output logic [3:0] dir_out,
    output logic       dir_changed,
    output logic [3:0] key_state
);

    logic [3:0] press;
    dir_t       cand;
    dir_t       ref_dir;
    dir_t       pending;
    logic       pending_valid;
    logic       commit;
    logic       accept;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .key_n (key_n[i]),
            .level (key_state[i]),
            .press (press[i])
        );
    end

    always_comb begin
        cand = 4'b0000;
        if      (press[3]) cand = DIR_UP;
        else if (press[2]) cand = DIR_DOWN;
        else if (press[1]) cand = DIR_LEFT;
        else if (press[0]) cand = DIR_RIGHT;

        commit = tick & pending_valid;
        // judge the press against what the snake will be doing after this edge
        ref_dir = commit ? pending : dir_t'(dir_out);
        accept  = (cand != 4'b0000) && (cand != ref_dir) &&
                  (cand != opposite_dir(ref_dir));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_out       <= DIR_RIGHT;
            dir_changed   <= 1'b0;
            pending       <= DIR_RIGHT;
            pending_valid <= 1'b0;
        end else begin
            dir_changed <= commit;
            if (commit) dir_out <= pending;
            if (accept) begin
                pending       <= cand;
                pending_valid <= 1'b1;
            end else if (commit) begin
                pending_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dir_control.sv
// Directed bench for dir_control with a 4-cycle debounce interval.
module tb_dir_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_n = 4'b1111;
    logic       tick = 1'b0;
    logic [3:0] dir_out;
    logic       dir_changed;
    logic [3:0] key_state;

    int errors = 0;
    int checks = 0;
    int chg_cnt = 0;
    int rise_cnt = 0;
    int cycles = 0;
    logic ks3_prev = 1'b0;

    dir_control #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .tick        (tick),
        .dir_out     (dir_out),
        .dir_changed (dir_changed),
        .key_state   (key_state)
    );

    always #5 clk = ~clk;

    // one clock: drive tick for this edge, sample 1 ns after it
    task automatic cyc(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
        cycles++;
        if (dir_changed === 1'b1) chg_cnt++;
        if (key_state[3] === 1'b1 && ks3_prev === 1'b0) rise_cnt++;
        ks3_prev = key_state[3];
        checks++;
        if (!$onehot(dir_out)) begin
            errors++;
            $display("FAIL onehot: dir_out=%b required exactly one bit set", dir_out);
        end
        if (cycles > 50000) begin
            $display("FAIL cycle_budget: cycles=%0d required <= 50000", cycles);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key_n = 4'b1111;
        cyc(1'b0);
        cyc(1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dir_out !== 4'b0001) begin errors++; $display("FAIL reset_dir: got %b want 0001", dir_out); end
        checks++; if (dir_changed !== 1'b0) begin errors++; $display("FAIL reset_chg: got %b want 0", dir_changed); end
        checks++; if (key_state !== 4'b0000) begin errors++; $display("FAIL reset_keys: got %b want 0000", key_state); end
        checks++; if (dut.pending_valid !== 1'b0) begin errors++; $display("FAIL reset_pv: got %b want 0", dut.pending_valid); end
    endtask

    task automatic test_idle();
        chg_cnt = 0;
        for (int i = 0; i < 20; i++) cyc(i % 5 == 4);
        checks++; if (dir_out !== 4'b0001) begin errors++; $display("FAIL idle_dir: got %b want 0001", dir_out); end
        checks++; if (chg_cnt !== 0) begin errors++; $display("FAIL idle_chg: got %0d want 0", chg_cnt); end
    endtask

    task automatic test_press_up();
        do_reset();
        chg_cnt = 0;
        key_n = 4'b0111;
        run(5);
        checks++; if (key_state !== 4'b0000) begin errors++; $display("FAIL up_early: got %b want 0000", key_state); end
        run(1);
        checks++; if (key_state !== 4'b1000) begin errors++; $display("FAIL up_level: got %b want 1000", key_state); end
        run(4);
        checks++; if (dut.pending_valid !== 1'b1) begin errors++; $display("FAIL up_pending: got %b want 1", dut.pending_valid); end
        checks++; if (dir_out !== 4'b0001) begin errors++; $display("FAIL up_hold: got %b want 0001", dir_out); end
        cyc(1'b1);
        checks++; if (dir_out !== 4'b1000) begin errors++; $display("FAIL up_commit: got %b want 1000", dir_out); end
        checks++; if (dir_changed !== 1'b1) begin errors++; $display("FAIL up_chg: got %b want 1", dir_changed); end
        for (int i = 0; i < 6; i++) cyc(i % 2 == 0);
        checks++; if (chg_cnt !== 1) begin errors++; $display("FAIL up_chg_once: got %0d want 1", chg_cnt); end
        key_n = 4'b1111;
        run(8);
        checks++; if (key_state !== 4'b0000) begin errors++; $display("FAIL up_release: got %b want 0000", key_state); end
        key_n = 4'b0111;
        run(8);
        checks++; if (dut.pending_valid !== 1'b0) begin errors++; $display("FAIL up_same_reject: got %b want 0", dut.pending_valid); end
        key_n = 4'b1111;
        run(8);
    endtask

    task automatic test_reject_opposite();
        do_reset();
        chg_cnt = 0;
        key_n = 4'b1101;
        run(8);
        checks++; if (dut.pending_valid !== 1'b0) begin errors++; $display("FAIL opp_pv: got %b want 0", dut.pending_valid); end
        cyc(1'b1);
        checks++; if (dir_out !== 4'b0001) begin errors++; $display("FAIL opp_dir: got %b want 0001", dir_out); end
        checks++; if (chg_cnt !== 0) begin errors++; $display("FAIL opp_chg: got %0d want 0", chg_cnt); end
        key_n = 4'b1111;
        run(8);
    endtask

    task automatic test_bounce();
        logic [9:0] pat;
        do_reset();
        rise_cnt = 0;
        pat = 10'b1100110011;
        for (int i = 9; i >= 2; i--) begin
            key_n = {~pat[i], 3'b111};
            cyc(1'b0);
        end
        key_n = 4'b0111;
        run(5);
        checks++; if (key_state[3] !== 1'b0) begin errors++; $display("FAIL bounce_early: got %b want 0", key_state[3]); end
        run(1);
        checks++; if (key_state[3] !== 1'b1) begin errors++; $display("FAIL bounce_level: got %b want 1", key_state[3]); end
        run(6);
        checks++; if (rise_cnt !== 1) begin errors++; $display("FAIL bounce_events: got %0d want 1", rise_cnt); end
        cyc(1'b1);
        checks++; if (dir_out !== 4'b1000) begin errors++; $display("FAIL bounce_dir: got %b want 1000", dir_out); end
        key_n = 4'b1111;
        run(8);
    endtask

    task automatic test_simultaneous();
        do_reset();
        key_n = 4'b0011;
        run(8);
        checks++; if (key_state !== 4'b1100) begin errors++; $display("FAIL simul_keys: got %b want 1100", key_state); end
        cyc(1'b1);
        checks++; if (dir_out !== 4'b1000) begin errors++; $display("FAIL simul_dir: got %b want 1000", dir_out); end
        key_n = 4'b1111;
        run(8);
    endtask

    task automatic test_back_to_back();
        do_reset();
        key_n = 4'b1011;
        run(8);
        checks++; if (dut.pending_valid !== 1'b1) begin errors++; $display("FAIL b2b_pv_down: got %b want 1", dut.pending_valid); end
        key_n = 4'b1001;
        run(6);
        cyc(1'b1);
        checks++; if (dir_out !== 4'b0100) begin errors++; $display("FAIL b2b_first: got %b want 0100", dir_out); end
        checks++; if (dir_changed !== 1'b1) begin errors++; $display("FAIL b2b_chg: got %b want 1", dir_changed); end
        checks++; if (dut.pending_valid !== 1'b1) begin errors++; $display("FAIL b2b_pv_left: got %b want 1", dut.pending_valid); end
        run(2);
        cyc(1'b1);
        checks++; if (dir_out !== 4'b0010) begin errors++; $display("FAIL b2b_second: got %b want 0010", dir_out); end
        key_n = 4'b1111;
        run(8);
    endtask

    task automatic test_reset_mid();
        do_reset();
        key_n = 4'b0111;
        run(4);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(5);
        checks++; if (key_state !== 4'b0000) begin errors++; $display("FAIL rmid_early: got %b want 0000", key_state); end
        run(1);
        checks++; if (key_state !== 4'b1000) begin errors++; $display("FAIL rmid_level: got %b want 1000", key_state); end
        key_n = 4'b1111;
        run(8);
        key_n = 4'b1011;
        run(8);
        rst = 1'b1;
        key_n = 4'b1111;
        cyc(1'b0);
        rst = 1'b0;
        chg_cnt = 0;
        for (int i = 0; i < 10; i++) cyc(i % 3 == 0);
        checks++; if (dir_out !== 4'b0001) begin errors++; $display("FAIL rpend_dir: got %b want 0001", dir_out); end
        checks++; if (chg_cnt !== 0) begin errors++; $display("FAIL rpend_chg: got %0d want 0", chg_cnt); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_press_up();
        test_reject_opposite();
        test_bounce();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
